// File: rtl/ioctl_txt_feeder_if.sv
// Handshake bundle between hps_io's ioctl download port, the TXT feeder and the
// receive-inject path. The slave modport is the feeder's view.
interface ioctl_txt_feeder_if;
  logic       ioctl_download;
  logic       ioctl_wr;
  logic [7:0] ioctl_index;
  logic [7:0] ioctl_data;
  logic       ioctl_wait;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (
    output ioctl_download, ioctl_wr, ioctl_index, ioctl_data, rx_ready,
    input  ioctl_wait, rx_data, rx_valid
  );

  modport slave (
    input  ioctl_download, ioctl_wr, ioctl_index, ioctl_data, rx_ready,
    output ioctl_wait, rx_data, rx_valid
  );
endinterface

// File: rtl/ioctl_txt_feeder.sv
// Buffers a downloaded TXT file and feeds it byte-by-byte, with pacing gaps, to the
// ACIA receive path. Define TXT_FEEDER_LF_TO_CR_EN to map LF/CRLF line endings to CR.
module ioctl_txt_feeder #(
  parameter int unsigned FIFO_AW     = 4,
  parameter int unsigned WAIT_MARGIN = 4,
  parameter int unsigned CHAR_GAP    = 48000,
  parameter int unsigned LINE_GAP    = 480000,
  parameter logic [7:0]  TXT_INDEX   = 8'd0
) (
  input  logic                clk_sys,
  input  logic                reset,
  ioctl_txt_feeder_if.slave   bus,
  output logic                active,
  output logic                overflow
);

  localparam int unsigned Depth  = 1 << FIFO_AW;
  localparam int unsigned GapMax = (LINE_GAP > CHAR_GAP) ? LINE_GAP : CHAR_GAP;
  localparam int unsigned GapW   = (GapMax > 2) ? $clog2(GapMax) : 1;
  localparam logic [FIFO_AW:0] WaitThresh = (FIFO_AW + 1)'(Depth - WAIT_MARGIN);

  typedef enum logic [1:0] {StIdle, StLoad, StPresent, StGap} state_e;

  state_e            state_q, state_d;
  logic [GapW-1:0]   gap_q, gap_d;
  logic [FIFO_AW:0]  wr_ptr_q, rd_ptr_q, count;
  logic [7:0]        mem [Depth];
  logic [7:0]        rx_data_q;
  logic              wait_q;
  logic              overflow_q;
  logic              dl_q;

  logic              empty, full, wr_en, pop, push, drop, dl_rise;
  logic [7:0]        head, byte_out;
  logic              filtered;

  assign count   = wr_ptr_q - rd_ptr_q;
  assign empty   = (count == '0);
  assign full    = count[FIFO_AW];
  assign wr_en   = bus.ioctl_wr & bus.ioctl_download & (bus.ioctl_index == TXT_INDEX);
  assign pop     = (state_q == StLoad) & ~empty;
  // A pop in the same cycle frees the slot, so a write into a full FIFO still lands.
  assign push    = wr_en & (~full | pop);
  assign drop    = wr_en & full & ~pop;
  assign dl_rise = bus.ioctl_download & ~dl_q;
  assign head    = mem[rd_ptr_q[FIFO_AW-1:0]];

`ifdef TXT_FEEDER_LF_TO_CR_EN
  logic prev_cr_q;

  assign filtered = (head == 8'h0A) & prev_cr_q;
  assign byte_out = (head == 8'h0A) ? 8'h0D : head;

  // Tracks the raw input byte, so a converted LF never swallows the next LF.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      prev_cr_q <= 1'b0;
    end else if (dl_rise) begin
      prev_cr_q <= 1'b0;
    end else if (pop) begin
      prev_cr_q <= (head == 8'h0D);
    end
  end
`else
  assign filtered = 1'b0;
  assign byte_out = head;
`endif

  always_ff @(posedge clk_sys) begin
    if (push) begin
      mem[wr_ptr_q[FIFO_AW-1:0]] <= bus.ioctl_data;
    end
  end

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    unique case (state_q)
      StIdle: begin
        if (!empty) state_d = StLoad;
      end
      StLoad: begin
        state_d = (pop && !filtered) ? StPresent : StIdle;
      end
      StPresent: begin
        if (bus.rx_ready) begin
          state_d = StGap;
          gap_d   = (rx_data_q == 8'h0D) ? GapW'(LINE_GAP - 1) : GapW'(CHAR_GAP - 1);
        end
      end
      StGap: begin
        if (gap_q == '0) begin
          state_d = StIdle;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      gap_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rx_data_q  <= '0;
      wait_q     <= 1'b0;
      overflow_q <= 1'b0;
      dl_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      dl_q    <= bus.ioctl_download;
      wait_q  <= (count >= WaitThresh);
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        if (!filtered) rx_data_q <= byte_out;
      end
      if (drop) begin
        overflow_q <= 1'b1;
      end else if (dl_rise) begin
        overflow_q <= 1'b0;
      end
    end
  end

  assign bus.ioctl_wait = wait_q & bus.ioctl_download;
  assign bus.rx_data    = rx_data_q;
  assign bus.rx_valid   = (state_q == StPresent);
  assign overflow       = overflow_q;
  assign active         = bus.ioctl_download | ~empty | (state_q != StIdle);

endmodule

// File: tb/tb_ioctl_txt_feeder.sv
// Directed bench for ioctl_txt_feeder with short pacing gaps (CHAR_GAP=4, LINE_GAP=20).
module tb_ioctl_txt_feeder;

  localparam int unsigned CharGap = 4;
  localparam int unsigned LineGap = 20;

  logic clk_sys = 1'b0;
  logic reset   = 1'b1;
  logic active, overflow;

  ioctl_txt_feeder_if bus ();

  ioctl_txt_feeder #(
    .FIFO_AW    (4),
    .WAIT_MARGIN(4),
    .CHAR_GAP   (CharGap),
    .LINE_GAP   (LineGap),
    .TXT_INDEX  (8'd0)
  ) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .bus     (bus),
    .active  (active),
    .overflow(overflow)
  );

  always #5 clk_sys = ~clk_sys;

  int checks = 0;
  int errors = 0;
  logic [7:0] got_q[$];
  int         t_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge clk_sys);
  endtask

  task automatic write_byte(input logic [7:0] data, input logic [7:0] idx);
    bus.ioctl_wr    = 1'b1;
    bus.ioctl_data  = data;
    bus.ioctl_index = idx;
    @(negedge clk_sys);
    bus.ioctl_wr    = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n = 0;
    while (!bus.rx_valid && n < budget) begin
      @(negedge clk_sys);
      n++;
    end
    check_eq(tag, {31'd0, bus.rx_valid}, 32'd1);
  endtask

  // Records every handshake (valid & ready seen before the next edge) with its cycle.
  task automatic collect(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      if (bus.rx_valid && bus.rx_ready) begin
        got_q.push_back(bus.rx_data);
        t_q.push_back(c);
      end
      @(negedge clk_sys);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    int stable;
    int first_wait;
    int n;
    logic [7:0] exp_lf [$];

    bus.ioctl_download = 1'b0;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_index    = 8'd0;
    bus.ioctl_data     = 8'd0;
    bus.rx_ready       = 1'b0;
    step(3);
    reset = 1'b0;
    step(1);

    check_eq("rst_rx_valid", {31'd0, bus.rx_valid}, 32'd0);
    check_eq("rst_rx_data", {24'd0, bus.rx_data}, 32'd0);
    check_eq("rst_wait", {31'd0, bus.ioctl_wait}, 32'd0);
    check_eq("rst_active", {31'd0, active}, 32'd0);
    check_eq("rst_overflow", {31'd0, overflow}, 32'd0);

    // Single byte: latency, hold while stalled, gap before the next byte.
    bus.ioctl_download = 1'b1;
    step(1);
    write_byte(8'h41, 8'd0);
    check_eq("lat_idle", {31'd0, bus.rx_valid}, 32'd0);
    step(1);
    check_eq("lat_load", {31'd0, bus.rx_valid}, 32'd0);
    step(1);
    check_eq("lat_present", {31'd0, bus.rx_valid}, 32'd1);
    check_eq("lat_data", {24'd0, bus.rx_data}, 32'h41);
    stable = 1;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (!bus.rx_valid || bus.rx_data !== 8'h41) stable = 0;
    end
    check_eq("hold_stable", stable, 1);
    bus.rx_ready = 1'b1;
    step(1);
    bus.rx_ready = 1'b0;
    check_eq("accept_drop", {31'd0, bus.rx_valid}, 32'd0);
    write_byte(8'h42, 8'd0);
    n = 1;
    while (!bus.rx_valid && n < 50) begin
      step(1);
      n++;
    end
    check_eq("char_gap_delay", n, CharGap + 2);
    check_eq("second_data", {24'd0, bus.rx_data}, 32'h42);
    bus.rx_ready = 1'b1;
    step(1);
    bus.rx_ready = 1'b0;
    step(10);

    // "AB\rC" streamed: handshake spacing CHAR_GAP+3, then LINE_GAP+3 after CR.
    write_byte(8'h41, 8'd0);
    write_byte(8'h42, 8'd0);
    write_byte(8'h0D, 8'd0);
    write_byte(8'h43, 8'd0);
    bus.rx_ready = 1'b1;
    got_q.delete();
    t_q.delete();
    collect(80);
    bus.rx_ready = 1'b0;
    check_eq("stream_count", got_q.size(), 4);
    if (got_q.size() == 4) begin
      check_eq("stream_d3", {24'd0, got_q[2]}, 32'h0D);
      check_eq("space_ab", t_q[1] - t_q[0], CharGap + 3);
      check_eq("space_bcr", t_q[2] - t_q[1], CharGap + 3);
      check_eq("space_cr", t_q[3] - t_q[2], LineGap + 3);
    end

    // Ignored strobes: wrong index, and write without download.
    write_byte(8'h55, 8'd1);
    bus.ioctl_download = 1'b0;
    step(1);
    write_byte(8'h66, 8'd0);
    step(10);
    check_eq("ignored_valid", {31'd0, bus.rx_valid}, 32'd0);
    check_eq("ignored_active", {31'd0, active}, 32'd0);

    // Overflow: one byte parked in PRESENT, then 20 writes into the 16-entry FIFO.
    bus.ioctl_download = 1'b1;
    step(1);
    write_byte(8'h55, 8'd0);
    wait_valid("ovf_park", 20);
    first_wait = 0;
    for (int i = 1; i <= 20; i++) begin
      bus.ioctl_wr   = 1'b1;
      bus.ioctl_data = 8'(i);
      step(1);
      if (bus.ioctl_wait && first_wait == 0) first_wait = i;
    end
    bus.ioctl_wr = 1'b0;
    check_eq("wait_first", first_wait, 13);
    check_eq("ovf_set", {31'd0, overflow}, 32'd1);
    bus.rx_ready = 1'b1;
    got_q.delete();
    t_q.delete();
    collect(200);
    bus.rx_ready = 1'b0;
    check_eq("drain_count", got_q.size(), 17);
    if (got_q.size() == 17) begin
      check_eq("drain_park", {24'd0, got_q[0]}, 32'h55);
      for (int i = 1; i <= 16; i++) check_eq($sformatf("drain_%0d", i), {24'd0, got_q[i]}, i);
    end
    check_eq("wait_clear", {31'd0, bus.ioctl_wait}, 32'd0);
    bus.ioctl_download = 1'b0;
    step(1);
    check_eq("ovf_sticky", {31'd0, overflow}, 32'd1);
    bus.ioctl_download = 1'b1;
    step(1);
    check_eq("ovf_cleared", {31'd0, overflow}, 32'd0);

    // Line-ending handling.
    write_byte(8'h0D, 8'd0);
    write_byte(8'h0A, 8'd0);
    write_byte(8'h0A, 8'd0);
    bus.rx_ready = 1'b1;
    got_q.delete();
    t_q.delete();
    collect(120);
    bus.rx_ready = 1'b0;
`ifdef TXT_FEEDER_LF_TO_CR_EN
    exp_lf = '{8'h0D, 8'h0D};
`else
    exp_lf = '{8'h0D, 8'h0A, 8'h0A};
`endif
    check_eq("lf_count", got_q.size(), exp_lf.size());
    if (got_q.size() == exp_lf.size()) begin
      foreach (exp_lf[i]) check_eq($sformatf("lf_%0d", i), {24'd0, got_q[i]}, {24'd0, exp_lf[i]});
    end

    // Reset mid-operation with bytes queued and overflow set.
    write_byte(8'h70, 8'd0);
    wait_valid("rst_park", 20);
    for (int i = 0; i < 20; i++) write_byte(8'h71, 8'd0);
    check_eq("pre_rst_ovf", {31'd0, overflow}, 32'd1);
    bus.ioctl_download = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check_eq("async_rx_valid", {31'd0, bus.rx_valid}, 32'd0);
    check_eq("async_active", {31'd0, active}, 32'd0);
    check_eq("async_overflow", {31'd0, overflow}, 32'd0);
    step(2);
    reset = 1'b0;
    step(5);
    check_eq("post_rst_valid", {31'd0, bus.rx_valid}, 32'd0);
    check_eq("post_rst_active", {31'd0, active}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ioctl_txt_feeder.md
Name: ioctl_txt_feeder

Overview:
- Sits between hps_io's ioctl download port and the uk101 serial receive path. Used when "Load programs from = File".
- Buffers bytes of a downloaded TXT file in a small FIFO and throttles hps_io via ioctl_wait.
- Presents bytes one at a time to the ACIA receive-inject path over a valid/ready handshake.
- Inserts programmable pacing gaps so the monitor/BASIC can keep up, with a longer gap after each CR.

Parameters:
- FIFO_AW, 4, log2 of FIFO depth; depth = 16 entries.
- WAIT_MARGIN, 4, ioctl_wait asserts when FIFO count >= depth - WAIT_MARGIN.
- CHAR_GAP, 48000, idle clk_sys cycles after each transferred byte (1 ms at 48 MHz).
- LINE_GAP, 480000, idle cycles after a transferred 0x0D (10 ms).
- TXT_INDEX, 8'd0, ioctl_index value that selects this block.

Ports:
- clk_sys  in  1  system clock, 48 MHz.
- reset  in  1  asynchronous reset, active-high.
- ioctl_download  in  1  download in progress.
- ioctl_wr  in  1  single-cycle byte-write strobe.
- ioctl_index  in  8  download slot index.
- ioctl_data  in  8  download byte.
- ioctl_wait  out  1  backpressure to hps_io.
- rx_data  out  8  byte offered to the receive path.
- rx_valid  out  1  rx_data valid.
- rx_ready  in  1  consumer accepts rx_data this cycle.
- active  out  1  transfer in progress; drives LED_USER.
- overflow  out  1  sticky: a byte was dropped.

Behaviour:
- Clock and reset: one clock (clk_sys). Reset is asynchronous, active-high (reset).
- Reset values: all outputs 0; FIFO empty; FSM in IDLE; gap counter 0; overflow 0; LF-suppress flag 0.
- FIFO write qualifier: ioctl_wr & ioctl_download & (ioctl_index == TXT_INDEX). Any other strobe is ignored.
- Write into a full FIFO: byte dropped, overflow set. overflow stays set until reset or a rising edge of ioctl_download.
- Pointers: FIFO_AW+1 bits wide and wrap naturally. count = wr_ptr - rd_ptr, range 0..16.
- Simultaneous read and write: both occur in the same cycle, including when the FIFO is full (the read frees the slot in that cycle) and when it is empty (the write is pushed; the pop is not possible).
- ioctl_wait: registered; asserted the cycle after count reaches >= depth - WAIT_MARGIN, deasserted the cycle after count falls below it. Also 0 whenever ioctl_download = 0.
- FSM states: IDLE, LOAD, PRESENT, GAP.
  - IDLE -> LOAD when FIFO is non-empty.
  - LOAD: pop the FIFO head into the rx_data register. Optionally filter the byte (see Optional Feature). Go to PRESENT, or back to IDLE if the byte is filtered.
  - PRESENT: rx_valid = 1. rx_data is held stable until rx_valid & rx_ready, with no timeout. On transfer: rx_valid -> 0 next cycle; gap counter loaded with LINE_GAP-1 if the byte was 0x0D, else CHAR_GAP-1; go to GAP.
  - GAP: decrement each cycle; at 0 go to IDLE.
- Latency: a byte written at cycle N into an empty FIFO with FSM in IDLE gives rx_valid = 1 at cycle N+3 (write N, IDLE sees non-empty N+1, LOAD N+2, PRESENT N+3).
- Back-to-back bytes: next rx_valid rises CHAR_GAP+3 cycles after the accepting edge.
- active = ioctl_download | (count != 0) | (state != IDLE).
- Download ending: the FIFO keeps draining after ioctl_download falls; bytes already buffered are never discarded except by reset.
- Reset mid-operation: the buffered byte and any partial gap are discarded immediately; rx_valid drops asynchronously.

Optional Feature:
- Macro: TXT_FEEDER_LF_TO_CR_EN.
- Defined: in LOAD, 0x0A immediately following a 0x0D is dropped (CRLF -> CR); any other 0x0A is converted to 0x0D (LF -> CR). The "previous byte was 0x0D" flag is cleared by reset and by the rising edge of ioctl_download.
- Undefined: bytes pass unmodified, and 0x0A uses CHAR_GAP.

Test Plan:
- Write 0x41 with index 0 into an idle block -> rx_valid high exactly 3 cycles later with rx_data=0x41; rx_ready held 0 for 100 cycles -> data stable; rx_ready=1 -> rx_valid low next cycle, next byte no earlier than CHAR_GAP+3 cycles.
- Burst 20 writes with rx_ready=0 while ignoring ioctl_wait -> ioctl_wait high once count >= 12; bytes 17..20 dropped, overflow=1; new download start clears overflow.
- Stream "AB\r" with rx_ready=1 and CHAR_GAP=4, LINE_GAP=20 -> handshake spacing 7, 7, then 23 cycles after the CR.
- Write with ioctl_index=1, or with ioctl_wr while ioctl_download=0 -> FIFO untouched, rx_valid stays 0.
- With TXT_FEEDER_LF_TO_CR_EN: input 0x0D,0x0A,0x0A -> output 0x0D,0x0D only; without the macro -> output 0x0D,0x0A,0x0A.
- Assert reset while in PRESENT with 5 bytes queued -> rx_valid, active, and overflow all 0 immediately, FIFO empty, IDLE after release.
